line_memory: RTL
================

# line_memory

Backing-store responder for the far side of the cache's `nextlevel` master port. It accepts one line-granular read or writeback request at a time, waits a programmable access latency, then commits the write or returns the line with a one-cycle `valid` pulse. It serves as the last level in the hierarchy in simulation, and as a slave model for verifying the cache miss and writeback paths.

## Interface
- `ADDRBITS`, 32: byte-address width.
- `WORDBITS`, 32: word width in bits.
- `LINEITEMS`, 64: words per line; line width = `LINEITEMS*WORDBITS`.
- `MEMLINES`, 1024: number of lines stored; power of two.
- `LATENCY`, 4: cycles from request acceptance to response; legal range 1..255.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `request` in 1: start a transaction; sampled only in IDLE.
- `write` in 1: 1 = writeback of `wdata`, 0 = line read; sampled with `request`.
- `addr` in `ADDRBITS`: byte address; offset bits below the line size are ignored.
- `wdata` in line width: writeback data; sampled with `request`.
- `rdata` out line width: line returned by the most recent read response.
- `valid` out 1: one-cycle response strobe.
- `busy` out 1: a transaction is in flight.
- `error` out 1: qualifies `valid`; the address was out of range.
- `overrun` out 1: sticky; a request arrived while busy.

## Operation
- `OFFBITS = $clog2(LINEITEMS*WORDBITS/8)`.
- Line index = `addr[OFFBITS +: $clog2(MEMLINES)]`.
- The address is out of range if any bit of `addr` above the index field is non-zero.
- Storage: `MEMLINES` lines, zero-initialised at time 0. `reset` does not clear storage.

States:
- **IDLE**
  - If `request`=1: capture `write`, index, `wdata`, and the range flag. Go to WAIT if `LATENCY>1`, else to RESPOND. Load the down-counter with `LATENCY-1`.
  - Otherwise stay in IDLE.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESPOND on the next edge. WAIT lasts exactly `LATENCY-1` cycles.
- **RESPOND** (one cycle), then return to IDLE.
  - `valid`=1.
  - In range, write: write the captured `wdata` into the line at the closing edge. `rdata` is unchanged.
  - In range, read: `rdata` shows the stored line during this cycle and holds it afterwards.
  - Out of range: `error`=1, no storage change, `rdata` driven to 0.

Outputs and flags:
- `busy`=1 in WAIT and RESPOND.
- `request`=1 while `busy`=1 is ignored (not queued) and sets `overrun`. Only `reset` clears `overrun`.
- Inputs other than `request` are don't-care outside the IDLE sampling cycle.
- A read issued after a write response to the same line returns the new data.

## Timing
- Reset values: state IDLE, `valid`=0, `busy`=0, `error`=0, `overrun`=0, `rdata`=0, counter 0.
- Request accepted in cycle N:
  - `busy` is high in cycles N+1 .. N+LATENCY.
  - `valid` is high only in cycle N+LATENCY.
  - `busy` is low in N+LATENCY+1.
- The earliest next request is accepted in cycle N+LATENCY+1, giving a throughput of one transaction per LATENCY+1 cycles.
- A request in the RESPOND cycle is dropped and sets `overrun`.
- `reset` asserted in WAIT or RESPOND:
  - Aborts the transaction; state returns to IDLE the next cycle.
  - No write is committed and no `valid` follows.
  - Outputs return to reset values.
- `reset` and `request` asserted in the same cycle: reset wins and the request is dropped.
- `error` and `valid` are asserted together; `error` is never high without `valid`.

## Test plan
- **Read after reset, `LATENCY`=4.** `request`=1, `write`=0, `addr`=0x100 in cycle 0 -> `busy` high in cycles 1–4; `valid`=1 only in cycle 4; `rdata`=0; `error`=0.
- **Write then read.** Write line 5 (`addr`=0x500) with word j = 0xA000+j. After `valid`, read 0x5F0 -> `rdata` word j = 0xA000+j. Line 4 still reads 0.
- **Out of range.** `addr`=0x0004_0000 with `MEMLINES`=1024 -> `valid` and `error` both high in cycle 4; `rdata`=0; a subsequent read of line 0 is unchanged.
- **Overrun.** A second `request` in cycle 2 of a transaction -> that request is ignored and `overrun`=1 from cycle 3 until `reset`; exactly one `valid` pulse occurs.
- **Reset mid-write.** Write to line 7; assert `reset` in cycle 2 -> no `valid`; a later read of line 7 returns 0.
- **`LATENCY`=1 back-to-back.** Requests in cycles 0 and 2 -> `valid` in cycles 1 and 3; `overrun`=0.

Source files
------------

// File: rtl/line_memory.sv
// line_memory: line-granular backing store answering one read or writeback
// at a time after a fixed access latency, with a one-cycle valid strobe.
module line_memory #(
    parameter int ADDRBITS  = 32,
    parameter int WORDBITS  = 32,
    parameter int LINEITEMS = 64,
    parameter int MEMLINES  = 1024,
    parameter int LATENCY   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          request,
    input  logic                          write,
    input  logic [ADDRBITS-1:0]           addr,
    input  logic [LINEITEMS*WORDBITS-1:0] wdata,
    output logic [LINEITEMS*WORDBITS-1:0] rdata,
    output logic                          valid,
    output logic                          busy,
    output logic                          error,
    output logic                          overrun
);

    localparam int LINEBITS = LINEITEMS * WORDBITS;
    localparam int OFFBITS  = $clog2(LINEBITS / 8);
    localparam int IDXBITS  = $clog2(MEMLINES);
    localparam int HIBITS   = OFFBITS + IDXBITS;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [7:0]           count;
    logic [7:0]           count_next;

    logic                 cap_write;
    logic                 cap_oor;
    logic [IDXBITS-1:0]   cap_index;
    logic [LINEBITS-1:0]  cap_wdata;
    logic [LINEBITS-1:0]  rdata_hold;
    logic [LINEBITS-1:0]  respond_line;
    logic                 read_respond;

    logic [ADDRBITS-1:0]  addr_upper;
    logic                 addr_oor;
    logic [IDXBITS-1:0]   addr_index;
    logic                 accept;

    // Backing store; starts zeroed and is never cleared by reset.
    logic [LINEBITS-1:0]  mem [MEMLINES] = '{default: '0};

    // Anything above the index field makes the address out of range.
    assign addr_upper = addr >> HIBITS;
    assign addr_oor   = |addr_upper;
    assign addr_index = addr[OFFBITS +: IDXBITS];
    assign accept     = (state == IDLE) && request;

    // A read response presents the line live in RESPOND and then holds it;
    // an out-of-range response of either kind presents zero.
    assign read_respond = (state == RESPOND) && (!cap_write || cap_oor);
    assign respond_line = cap_oor ? '0 : mem[cap_index];
    assign rdata        = read_respond ? respond_line : rdata_hold;

    // State register and latency down-counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state logic and response strobes.
    always_comb begin
        state_next = state;
        count_next = count;
        valid      = 1'b0;
        busy       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    count_next = 8'(LATENCY - 1);
                    state_next = (LATENCY > 1) ? WAIT : RESPOND;
                end
            end
            WAIT: begin
                busy       = 1'b1;
                count_next = count - 8'd1;
                if (count == 8'd1) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                busy       = 1'b1;
                valid      = 1'b1;
                error      = cap_oor;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the request fields when a transaction is accepted.
    always_ff @(posedge clock) begin
        if (accept) begin
            cap_write <= write;
            cap_oor   <= addr_oor;
            cap_index <= addr_index;
            cap_wdata <= wdata;
        end
    end

    // Sticky flag for requests arriving while a transaction is in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (request && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

    // Hold the line returned by the most recent read response.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_hold <= '0;
        end else if (read_respond) begin
            rdata_hold <= respond_line;
        end
    end

    // Commit an in-range writeback at the closing edge of RESPOND.
    always_ff @(posedge clock) begin
        if (!reset && (state == RESPOND) && cap_write && !cap_oor) begin
            mem[cap_index] <= cap_wdata;
        end
    end

endmodule
